// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings, FSM states
// and the byte-lane helpers used by the data-memory request path.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int BE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_half(input logic [2:0] f3, input logic we);
        return (f3 == F3_SH) || (!we && (f3 == F3_LHU));
    endfunction

    function automatic logic is_byte(input logic [2:0] f3, input logic we);
        return (f3 == F3_SB) || (!we && (f3 == F3_LBU));
    endfunction

    function automatic logic is_word(input logic [2:0] f3);
        return f3 == F3_SW;
    endfunction

    // Loads and stores share the lane mapping; an undefined size enables no lanes.
    function automatic logic [BE_W-1:0] calc_be(input logic [2:0] f3, input logic we,
                                                input logic [1:0] a);
        logic [BE_W-1:0] be;
        be = '0;
        if (is_byte(f3, we))
            be = 4'b0001 << a;
        else if (is_half(f3, we))
            be = a[1] ? 4'b1100 : 4'b0011;
        else if (is_word(f3))
            be = 4'b1111;
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_SB:   d = {4{wd[7:0]}};
            F3_SH:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic we,
                                           input logic [1:0] a);
        return (is_half(f3, we) && a[0]) || (is_word(f3) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Valid/ready data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    import mem_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [31:0]     dmem_addr;
    logic [BE_W-1:0] dmem_be;
    logic [31:0]     dmem_wdata;
    logic            dmem_ready;
    logic [31:0]     dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension of the returned data-memory word.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // A misaligned half falls back to the half selected by addr[1].
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load = '0;
        case (i_funct3)
            F3_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_load = {24'h0, w_byte};
            F3_LH:   o_load = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_load = {16'h0, w_half};
            F3_LW:   o_load = i_rdata;
            default: o_load = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory bus, stalls upstream while an access waits,
// registers MEM/WB. Optional misalignment trap enabled by MEM_MISALIGN_TRAP_EN.
//
//  state | meaning
//  IDLE  | no access outstanding; zero-wait accesses complete here
//  WAIT  | access issued, holding request until dmem_ready or timeout
module mem_stage
    import mem_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_ALU_result,
    input  logic [31:0] EX_MEM_WriteData,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [2:0]  EX_MEM_funct3,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_RegWrite,
    input  logic [1:0]  EX_MEM_ResultSrc,
    input  logic [31:0] EX_MEM_pcPlus4,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic [31:0] MEM_WB_ALU_result,
    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_pcPlus4,
    output logic [4:0]  MEM_WB_rd,
    output logic [1:0]  MEM_WB_ResultSrc,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_bus_err,
    output logic        MEM_WB_misalign
);

    localparam int CNT_W = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

    mem_state_t       r_state;
    mem_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic        w_access;
    logic        w_trap;
    logic        w_bus_access;
    logic        w_active;
    logic        w_complete;
    logic        w_timeout;
    logic [1:0]  w_a;
    logic [31:0] w_load;

    assign w_access = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign w_a      = EX_MEM_ALU_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = is_misaligned(EX_MEM_funct3, EX_MEM_MemWrite, w_a);
    assign w_trap     = w_access & w_misalign;
`else
    assign w_trap     = 1'b0;
`endif

    assign w_bus_access = w_access & ~w_trap;
    assign w_active     = (r_state == WAIT) | w_bus_access;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_bus_access) begin
                    if (dmem.dmem_ready)
                        w_complete = 1'b1;
                    else
                        w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (dmem.dmem_ready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_complete  = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Reset gates the request combinationally so an abandoned access drops at once.
    assign dmem.dmem_req   = ~rst & w_active;
    assign dmem.dmem_we    = EX_MEM_MemWrite;
    assign dmem.dmem_addr  = {EX_MEM_ALU_result[31:2], 2'b00};
    assign dmem.dmem_be    = calc_be(EX_MEM_funct3, EX_MEM_MemWrite, w_a);
    assign dmem.dmem_wdata = calc_wdata(EX_MEM_funct3, EX_MEM_WriteData);
    assign mem_stall       = ~rst & w_active & ~w_complete;

    load_align u_load_align (
        .i_rdata   (dmem.dmem_rdata),
        .i_addr_lo (w_a),
        .i_funct3  (EX_MEM_funct3),
        .o_load    (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_WB_ALU_result <= '0;
            MEM_WB_ReadData   <= '0;
            MEM_WB_pcPlus4    <= '0;
            MEM_WB_rd         <= '0;
            MEM_WB_ResultSrc  <= '0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_bus_err    <= 1'b0;
            MEM_WB_misalign   <= 1'b0;
        end else if (mem_stall) begin
            MEM_WB_ALU_result <= '0;
            MEM_WB_ReadData   <= '0;
            MEM_WB_pcPlus4    <= '0;
            MEM_WB_rd         <= '0;
            MEM_WB_ResultSrc  <= '0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_bus_err    <= 1'b0;
            MEM_WB_misalign   <= 1'b0;
        end else begin
            MEM_WB_ALU_result <= EX_MEM_ALU_result;
            MEM_WB_ReadData   <= (w_complete && !w_timeout && !EX_MEM_MemWrite) ? w_load : '0;
            MEM_WB_pcPlus4    <= EX_MEM_pcPlus4;
            MEM_WB_rd         <= EX_MEM_rd;
            MEM_WB_ResultSrc  <= EX_MEM_ResultSrc;
            MEM_WB_RegWrite   <= EX_MEM_RegWrite & ~w_timeout & ~w_trap;
            MEM_WB_bus_err    <= w_timeout;
            MEM_WB_misalign   <= w_trap;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage; expected MEM/WB entries are queued per cycle.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] EX_MEM_ALU_result, EX_MEM_WriteData, EX_MEM_pcPlus4;
    logic [4:0]  EX_MEM_rd;
    logic [2:0]  EX_MEM_funct3;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite;
    logic [1:0]  EX_MEM_ResultSrc;
    logic        mem_stall;
    logic [31:0] MEM_WB_ALU_result, MEM_WB_ReadData, MEM_WB_pcPlus4;
    logic [4:0]  MEM_WB_rd;
    logic [1:0]  MEM_WB_ResultSrc;
    logic        MEM_WB_RegWrite, MEM_WB_bus_err, MEM_WB_misalign;

    mem_stage_if dmem ();

    always #5 clk = ~clk;

    mem_stage #(.DMEM_TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .EX_MEM_ALU_result (EX_MEM_ALU_result),
        .EX_MEM_WriteData  (EX_MEM_WriteData),
        .EX_MEM_rd         (EX_MEM_rd),
        .EX_MEM_funct3     (EX_MEM_funct3),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .EX_MEM_RegWrite   (EX_MEM_RegWrite),
        .EX_MEM_ResultSrc  (EX_MEM_ResultSrc),
        .EX_MEM_pcPlus4    (EX_MEM_pcPlus4),
        .dmem              (dmem),
        .mem_stall         (mem_stall),
        .MEM_WB_ALU_result (MEM_WB_ALU_result),
        .MEM_WB_ReadData   (MEM_WB_ReadData),
        .MEM_WB_pcPlus4    (MEM_WB_pcPlus4),
        .MEM_WB_rd         (MEM_WB_rd),
        .MEM_WB_ResultSrc  (MEM_WB_ResultSrc),
        .MEM_WB_RegWrite   (MEM_WB_RegWrite),
        .MEM_WB_bus_err    (MEM_WB_bus_err),
        .MEM_WB_misalign   (MEM_WB_misalign)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  rsrc;
        logic        regw;
        logic        berr;
        logic        mis;
        logic        bubble;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] alu, input logic [31:0] rdat,
                                input logic [31:0] pc, input logic [4:0] rd,
                                input logic [1:0] rsrc, input logic regw,
                                input logic berr, input logic mis);
        exp_t e;
        e.alu = alu; e.rdat = rdat; e.pc = pc; e.rd = rd; e.rsrc = rsrc;
        e.regw = regw; e.berr = berr; e.mis = mis; e.bubble = 1'b0;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = mk('0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        e.bubble = 1'b1;
        return e;
    endfunction

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic regw, input logic [1:0] rsrc,
                         input logic [31:0] pc);
        EX_MEM_MemRead    = rd_en;
        EX_MEM_MemWrite   = wr_en;
        EX_MEM_funct3     = f3;
        EX_MEM_ALU_result = addr;
        EX_MEM_WriteData  = wdata;
        EX_MEM_rd         = rd;
        EX_MEM_RegWrite   = regw;
        EX_MEM_ResultSrc  = rsrc;
        EX_MEM_pcPlus4    = pc;
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic stall);
        @(negedge clk);
        chk({tag, ".req"}, dmem.dmem_req, req);
        chk({tag, ".stall"}, mem_stall, stall);
    endtask

    task automatic chk_bus(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic we, input logic [31:0] wdata);
        chk({tag, ".addr"}, dmem.dmem_addr, addr);
        chk({tag, ".be"}, dmem.dmem_be, be);
        chk({tag, ".we"}, dmem.dmem_we, we);
        chk({tag, ".wdata"}, dmem.dmem_wdata, wdata);
    endtask

    task automatic commit(input string tag, input exp_t e);
        exp_t g;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        if (!g.bubble) begin
            chk({tag, ".wb_alu"}, MEM_WB_ALU_result, g.alu);
            chk({tag, ".wb_rdata"}, MEM_WB_ReadData, g.rdat);
            chk({tag, ".wb_pc"}, MEM_WB_pcPlus4, g.pc);
            chk({tag, ".wb_rsrc"}, MEM_WB_ResultSrc, g.rsrc);
        end
        chk({tag, ".wb_rd"}, MEM_WB_rd, g.rd);
        chk({tag, ".wb_regw"}, MEM_WB_RegWrite, g.regw);
        chk({tag, ".wb_berr"}, MEM_WB_bus_err, g.berr);
        chk({tag, ".wb_mis"}, MEM_WB_misalign, g.mis);
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, ".alu0"}, MEM_WB_ALU_result, 32'h0);
        chk({tag, ".rdata0"}, MEM_WB_ReadData, 32'h0);
        chk({tag, ".pc0"}, MEM_WB_pcPlus4, 32'h0);
        chk({tag, ".rd0"}, MEM_WB_rd, 32'h0);
        chk({tag, ".rsrc0"}, MEM_WB_ResultSrc, 32'h0);
        chk({tag, ".regw0"}, MEM_WB_RegWrite, 32'h0);
        chk({tag, ".berr0"}, MEM_WB_bus_err, 32'h0);
        chk({tag, ".mis0"}, MEM_WB_misalign, 32'h0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 32'h0);
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 32'h0;
        #1 rst = 1'b1;
        #11;
        chk_wb_zero("reset");
        chk("reset.req", dmem.dmem_req, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // zero-wait store
        drive(1'b0, 1'b1, F3_SW, 32'h104, 32'hDEADBEEF, 5'd5, 1'b0, 2'd0, 32'h1000);
        dmem.dmem_ready = 1'b1;
        chk_ctl("sw", 1'b1, 1'b0);
        chk_bus("sw", 32'h104, 4'hF, 1'b1, 32'hDEADBEEF);
        commit("sw", mk(32'h104, 32'h0, 32'h1000, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0));

        drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd6, 1'b1, 2'd0, 32'h1004);
        dmem.dmem_ready = 1'b0;
        chk_ctl("alu", 1'b0, 1'b0);
        commit("alu", mk(32'h55, 32'h0, 32'h1004, 5'd6, 2'd0, 1'b1, 1'b0, 1'b0));

        // LB with three wait cycles
        drive(1'b1, 1'b0, F3_LB, 32'h203, 32'h0, 5'd7, 1'b1, 2'd1, 32'h2000);
        for (int i = 0; i < 3; i++) begin
            chk_ctl("lb_wait", 1'b1, 1'b1);
            chk_bus("lb_wait", 32'h200, 4'b1000, 1'b0, 32'h0);
            commit("lb_wait", bub());
        end
        dmem.dmem_ready = 1'b1;
        dmem.dmem_rdata = 32'h80FF7F01;
        chk_ctl("lb", 1'b1, 1'b0);
        commit("lb", mk(32'h203, 32'hFFFFFF80, 32'h2000, 5'd7, 2'd1, 1'b1, 1'b0, 1'b0));

        drive(1'b0, 1'b1, F3_SH, 32'h302, 32'h0000ABCD, 5'd0, 1'b0, 2'd0, 32'h3000);
        chk_ctl("sh", 1'b1, 1'b0);
        chk_bus("sh", 32'h300, 4'b1100, 1'b1, 32'hABCDABCD);
        commit("sh", mk(32'h302, 32'h0, 32'h3000, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0));

        drive(1'b1, 1'b0, F3_LHU, 32'h302, 32'h0, 5'd9, 1'b1, 2'd1, 32'h3004);
        dmem.dmem_rdata = 32'hABCD1234;
        chk_ctl("lhu", 1'b1, 1'b0);
        chk_bus("lhu", 32'h300, 4'b1100, 1'b0, 32'h0);
        commit("lhu", mk(32'h302, 32'h0000ABCD, 32'h3004, 5'd9, 2'd1, 1'b1, 1'b0, 1'b0));

        drive(1'b1, 1'b0, F3_LH, 32'h300, 32'h0, 5'd10, 1'b1, 2'd1, 32'h3008);
        dmem.dmem_rdata = 32'h00008001;
        chk_ctl("lh", 1'b1, 1'b0);
        chk("lh.be", dmem.dmem_be, 4'b0011);
        commit("lh", mk(32'h300, 32'hFFFF8001, 32'h3008, 5'd10, 2'd1, 1'b1, 1'b0, 1'b0));

        drive(1'b1, 1'b0, F3_LBU, 32'h301, 32'h0, 5'd11, 1'b1, 2'd1, 32'h300C);
        dmem.dmem_rdata = 32'h0000F200;
        chk_ctl("lbu", 1'b1, 1'b0);
        chk("lbu.be", dmem.dmem_be, 4'b0010);
        commit("lbu", mk(32'h301, 32'h000000F2, 32'h300C, 5'd11, 2'd1, 1'b1, 1'b0, 1'b0));

        drive(1'b0, 1'b1, F3_SB, 32'h501, 32'h1234565A, 5'd0, 1'b0, 2'd0, 32'h3010);
        chk_ctl("sb", 1'b1, 1'b0);
        chk_bus("sb", 32'h500, 4'b0010, 1'b1, 32'h5A5A5A5A);
        commit("sb", mk(32'h501, 32'h0, 32'h3010, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0));

        // undefined size still handshakes, enables no lanes, returns zero
        drive(1'b1, 1'b0, 3'b011, 32'h600, 32'h0, 5'd12, 1'b1, 2'd1, 32'h3014);
        dmem.dmem_rdata = 32'hFFFFFFFF;
        chk_ctl("undef", 1'b1, 1'b0);
        chk("undef.be", dmem.dmem_be, 4'b0000);
        commit("undef", mk(32'h600, 32'h0, 32'h3014, 5'd12, 2'd1, 1'b1, 1'b0, 1'b0));

        drive(1'b1, 1'b1, F3_SW, 32'h108, 32'h11223344, 5'd13, 1'b0, 2'd0, 32'h3018);
        chk_ctl("rdwr", 1'b1, 1'b0);
        chk_bus("rdwr", 32'h108, 4'hF, 1'b1, 32'h11223344);
        commit("rdwr", mk(32'h108, 32'h0, 32'h3018, 5'd13, 2'd0, 1'b0, 1'b0, 1'b0));

        // timeout: 16 stalled cycles then a bus error completion
        drive(1'b1, 1'b0, F3_LW, 32'h600, 32'h0, 5'd3, 1'b1, 2'd1, 32'h4000);
        dmem.dmem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_ctl("to_wait", 1'b1, 1'b1);
            commit("to_wait", bub());
        end
        chk_ctl("to_done", 1'b1, 1'b0);
        commit("to_done", mk(32'h600, 32'h0, 32'h4000, 5'd3, 2'd1, 1'b0, 1'b1, 1'b0));

        drive(1'b1, 1'b0, F3_LW, 32'h604, 32'h0, 5'd4, 1'b1, 2'd1, 32'h4004);
        dmem.dmem_ready = 1'b1;
        dmem.dmem_rdata = 32'h12345678;
        chk_ctl("lw", 1'b1, 1'b0);
        commit("lw", mk(32'h604, 32'h12345678, 32'h4004, 5'd4, 2'd1, 1'b1, 1'b0, 1'b0));

        // misaligned accesses
        drive(1'b1, 1'b0, F3_LW, 32'h401, 32'h0, 5'd8, 1'b1, 2'd1, 32'h5000);
        dmem.dmem_rdata = 32'hCAFEF00D;
`ifdef MEM_MISALIGN_TRAP_EN
        chk_ctl("mis_lw", 1'b0, 1'b0);
        commit("mis_lw", mk(32'h401, 32'h0, 32'h5000, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1));
        drive(1'b1, 1'b0, F3_LH, 32'h403, 32'h0, 5'd8, 1'b1, 2'd1, 32'h5004);
        chk_ctl("mis_lh", 1'b0, 1'b0);
        commit("mis_lh", mk(32'h403, 32'h0, 32'h5004, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1));
`else
        chk_ctl("mis_lw", 1'b1, 1'b0);
        chk_bus("mis_lw", 32'h400, 4'hF, 1'b0, 32'h0);
        commit("mis_lw", mk(32'h401, 32'hCAFEF00D, 32'h5000, 5'd8, 2'd1, 1'b1, 1'b0, 1'b0));
        drive(1'b1, 1'b0, F3_LH, 32'h403, 32'h0, 5'd8, 1'b1, 2'd1, 32'h5004);
        chk_ctl("mis_lh", 1'b1, 1'b0);
        chk("mis_lh.be", dmem.dmem_be, 4'b1100);
        commit("mis_lh", mk(32'h403, 32'hFFFFCAFE, 32'h5004, 5'd8, 2'd1, 1'b1, 1'b0, 1'b0));
`endif

        // reset clears a populated MEM/WB
        drive(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd14, 1'b1, 2'd2, 32'h6000);
        dmem.dmem_ready = 1'b0;
        chk_ctl("pre_rst", 1'b0, 1'b0);
        commit("pre_rst", mk(32'h77, 32'h0, 32'h6000, 5'd14, 2'd2, 1'b1, 1'b0, 1'b0));
        rst = 1'b1;
        #1;
        chk_wb_zero("rst_wb");
        @(posedge clk);
        #1 rst = 1'b0;

        // reset during WAIT abandons the access; the retry waits the full timeout again
        drive(1'b1, 1'b0, F3_LW, 32'h700, 32'h0, 5'd15, 1'b1, 2'd1, 32'h7000);
        for (int i = 0; i < 2; i++) begin
            chk_ctl("rw_wait", 1'b1, 1'b1);
            commit("rw_wait", bub());
        end
        rst = 1'b1;
        #1;
        chk("rst_wait.req", dmem.dmem_req, 1'b0);
        chk("rst_wait.stall", mem_stall, 1'b0);
        chk_wb_zero("rst_wait");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_ctl("retry_wait", 1'b1, 1'b1);
            commit("retry_wait", bub());
        end
        chk_ctl("retry_to", 1'b1, 1'b0);
        commit("retry_to", mk(32'h700, 32'h0, 32'h7000, 5'd15, 2'd1, 1'b0, 1'b1, 1'b0));

        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 32'h0);
        chk_ctl("idle_end", 1'b0, 1'b0);
        commit("idle_end", mk(32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM pipeline stage sitting directly downstream of the EX/MEM register and upstream of the MEM/WB register.
- Drives a valid/ready data-memory bus with word-aligned address, byte enables and lane-aligned store data.
- Sign/zero-extends load data and registers the MEM/WB outputs.
- Raises mem_stall to freeze IF..EX/MEM while a memory access waits.

Parameters:
DMEM_TIMEOUT, 16, maximum wait cycles for dmem_ready before the access is forced complete with bus error.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
EX_MEM_ALU_result  in  32  effective address / ALU result
EX_MEM_WriteData  in  32  forwarded store data
EX_MEM_rd  in  5  destination register
EX_MEM_funct3  in  3  access size/sign
EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite  in  1 each  control
EX_MEM_ResultSrc  in  2  writeback select
EX_MEM_pcPlus4  in  32  link value
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ready  in  1  access complete this cycle
dmem_rdata  in  32  read word, valid with dmem_ready
mem_stall  out  1  freeze upstream stages
MEM_WB_ALU_result, MEM_WB_ReadData, MEM_WB_pcPlus4  out  32 each  registered results
MEM_WB_rd  out  5; MEM_WB_ResultSrc  out  2; MEM_WB_RegWrite  out  1
MEM_WB_bus_err  out  1  access timed out
MEM_WB_misalign  out  1  misaligned access flag

Behaviour:
- Reset (async, rst=1): FSM=IDLE, wait counter=0, all MEM_WB_* outputs=0.
- Reset asserted mid-access: abandons the access immediately and drops dmem_req the same cycle.
- access = MemRead|MemWrite. If both are set, the access is treated as a store.
- FSM IDLE:
  - dmem_req = access, combinational.
  - If dmem_ready is also 1: zero-wait completion, no stall.
  - Otherwise go to WAIT.
- FSM WAIT:
  - dmem_req=1; address, be, wdata and we held stable (EX/MEM is frozen by mem_stall).
  - Counter increments each cycle.
  - Returns to IDLE on dmem_ready, or when counter reaches DMEM_TIMEOUT-1.
- mem_stall = access & !complete, combinational.
- While stalled, MEM/WB captures a bubble: RegWrite=0, rd=0, flags=0.
- On completion or non-memory op: MEM/WB captures the EX/MEM fields. ReadData = extracted load, or 0 for stores/non-memory ops.
- Timeout completion: ReadData=0, RegWrite=0, MEM_WB_bus_err=1 for one cycle.
- Latency: one cycle from completing edge to MEM_WB_*.
- Stores, with a = addr[1:0]:
  - SB (000): be = 1<<a; wdata = byte replicated x4.
  - SH (001): be = 4'b0011<<(a[1]*2); wdata = half replicated x2.
  - SW (010): be = 4'hF.
- Loads select the lane by a:
  - LB (000) / LBU (100): sign / zero extend the byte.
  - LH (001) / LHU (101): sign / zero extend the half.
  - LW (010): full word.
- Undefined funct3 with access: be=0, ReadData=0; treated as a no-op access that still handshakes.
- Misaligned: half with a[0]=1, or word with a!=0.

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no dmem_req and no stall. MEM/WB captures RegWrite=0 and MEM_WB_misalign=1 for one cycle.
- Undefined: MEM_WB_misalign tied 0. Misaligned half uses lane a[1] and misaligned word uses lane 0; the access proceeds normally.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - The FSM state enum {IDLE, WAIT}.
  - Byte-enable width constant.
- One natural sub-module: load_align. It is combinational and takes rdata, addr[1:0] and funct3, producing the extended 32-bit load value.

Test Plan:
1. SW addr 0x104, data 0xDEADBEEF, dmem_ready=1 same cycle -> dmem_be=F, dmem_addr=0x104, no stall, next cycle MEM_WB_ReadData=0, RegWrite follows input.
2. LB addr 0x203, rdata 0x80FF7F01, ready after 3 cycles -> mem_stall high 3 cycles with MEM/WB bubbles (RegWrite=0), then MEM_WB_ReadData=0xFFFFFF80.
3. SH addr 0x302, data 0x0000ABCD -> be=4'b1100, wdata=0xABCDABCD. Then LHU same addr, rdata 0xABCD1234 -> ReadData=0x0000ABCD.
4. LW with dmem_ready never asserted -> stall exactly 16 cycles, then MEM_WB_bus_err=1, RegWrite=0, FSM IDLE.
5. LW addr 0x401 with MEM_MISALIGN_TRAP_EN defined -> no dmem_req, no stall, MEM_WB_misalign=1, RegWrite=0. Without the macro -> request at 0x400, be=F.
6. rst pulsed during WAIT -> dmem_req drops immediately, all MEM_WB_* = 0, the next access starts from IDLE.
